data_memory_pipe: RTL
=====================

DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 Parameter DATA_W, default 16: data word width in bits; SHALL be a multiple of 8, minimum 16.
REQ-002 Parameter ADDR_W, default 16: byte-address width.
REQ-003 Parameter DEPTH_LOG2, default 8: memory holds 2**DEPTH_LOG2 words.
REQ-004 Parameter RD_LAT, default 1: response latency in cycles, legal range 1..4.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  DATA_W  write data.
REQ-012 req_be  in  DATA_W/8  byte-write enables; bit k covers bits [8k+7:8k].
REQ-013 rsp_valid  out  1  response present; one-cycle pulse per accepted request.
REQ-014 rsp_rdata  out  DATA_W  read data; 0 for writes and errored requests.
REQ-015 rsp_err  out  1  accepted request was out of range.
REQ-016 init_busy  out  1  memory clear in progress.

Function
REQ-017 B = log2(DATA_W/8); word index = req_addr[DEPTH_LOG2+B-1:B]; address bits below B SHALL be ignored.
REQ-018 Out of range: any req_addr bit at or above DEPTH_LOG2+B is 1.
REQ-019 State machine: INIT, RUN.
REQ-020 INIT: one word zeroed per cycle, index 0 up to 2**DEPTH_LOG2-1; init_busy=1, req_ready=0.
REQ-021 Last word zeroed -> RUN next cycle; INIT lasts exactly 2**DEPTH_LOG2 cycles after reset release.
REQ-022 RUN: req_ready=1 and init_busy=0 every cycle; no backpressure.
REQ-023 Request accepted on a rising edge where req_valid & req_ready = 1; one request per cycle, back-to-back allowed.
REQ-024 Accepted in-range write: bytes with req_be=1 updated at the accepting edge; other bytes unchanged.
REQ-025 req_be = 0: no byte changes; a normal response is still produced.
REQ-026 Accepted read: data sampled from the array at the accepting edge.
REQ-027 Each accepted request: exactly one response, rsp_valid high for one cycle, RD_LAT cycles after the accepting edge.
REQ-028 Responses return in acceptance order.
REQ-029 Latency shift register RD_LAT deep carries valid, err and data.
REQ-030 Read accepted the cycle after a write to the same word: returns the post-write data.
REQ-031 Out-of-range request: no array change, rsp_err=1, rsp_rdata=0.
REQ-032 Cycles with no response: rsp_rdata=0 and rsp_err=0.
REQ-033 Write response: rsp_rdata=0.
REQ-034 Array read and write are single-ported; no request is taken while in INIT.

Reset
REQ-035 rst_n=0 at an edge: state -> INIT, init index -> 0, latency pipeline cleared.
REQ-036 Outputs during and after reset: rsp_valid=0, rsp_err=0, rsp_rdata=0, req_ready=0, init_busy=1.
REQ-037 Reset mid-operation (RUN or INIT): in-flight responses are dropped and never appear; after release the memory is cleared again before any request is accepted.
REQ-038 Array contents are undefined only while INIT is in progress; the array reads 0 everywhere on entry to RUN.

Verification
REQ-039 Init check: release reset, count cycles with init_busy=1 -> exactly 256 (defaults); then read 0x0000 and 0x01FE -> rsp_rdata=0x0000, rsp_err=0.
REQ-040 Byte enables: write 0xABCD to 0x0010 with be=11; then write 0x0012 to 0x0010 with be=01; read 0x0010 -> 0xAB12. Also read 0x0011 (low bit ignored) -> 0xAB12.
REQ-041 Latency: RD_LAT=3; write 0x1234 to 0x0004, then read 0x0004 the next cycle -> read rsp_valid exactly 3 cycles after acceptance with 0x1234; both responses arrive in order.
REQ-042 Back-to-back streaming: 256 consecutive writes with data=index, then 256 consecutive reads -> 256 in-order responses with data=index and no gaps.
REQ-043 Out of range: write 0xFFFF to 0x0200 -> rsp_err=1 and rsp_rdata=0; a later read of 0x0000 -> 0x0000 (no aliasing).
REQ-044 Reset mid-stream: issue 3 reads with RD_LAT=4, assert rst_n=0 one cycle later -> no rsp_valid pulse; after release, INIT runs again and a read of a previously written word -> 0x0000.

Source files
------------

// File: rtl/data_memory_pipe.sv
// Word-addressed data memory with byte enables, a fixed-latency response pipeline,
// and a self-clearing INIT phase that zeroes every word after reset.
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | zeroing one word per cycle; requests are refused
// RUN   | one request per cycle, response RD_LAT cycles later
module data_memory_pipe #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int B     = $clog2(NB);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                          state_q, state_d;
    logic [DEPTH_LOG2-1:0]           init_idx_q, init_idx_d;
    logic [RD_LAT-1:0]               pv_q, pv_d;
    logic [RD_LAT-1:0]               pe_q, pe_d;
    logic [RD_LAT-1:0][DATA_W-1:0]   pd_q, pd_d;
    logic [DATA_W-1:0]               mem_q [DEPTH];

    logic                            acc;
    logic                            oor;
    logic [DEPTH_LOG2-1:0]           req_idx;
    logic [DATA_W-1:0]               be_mask;
    logic [DATA_W-1:0]               rd_word;
    logic                            wr_en;
    logic [DEPTH_LOG2-1:0]           wr_idx;
    logic [DATA_W-1:0]               wr_data;
    logic [DATA_W-1:0]               wr_mask;

    // Request decode; any address bit above the word index marks the access out of range.
    always_comb begin
        req_idx = DEPTH_LOG2'(req_addr >> B);
        oor     = |(req_addr >> (DEPTH_LOG2 + B));
        acc     = req_valid & req_ready;
        rd_word = mem_q[req_idx];
        be_mask = '0;
        for (int k = 0; k < NB; k++) begin
            be_mask[8*k +: 8] = {8{req_be[k]}};
        end
    end

    // Single write port shared between the INIT clear and accepted writes.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = req_idx;
        wr_data = '0;
        wr_mask = '0;
        if (state_q == ST_INIT) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx_q;
            wr_mask = '1;
        end else if (acc && req_we && !oor) begin
            wr_en   = 1'b1;
            wr_data = req_wdata;
            wr_mask = be_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= (mem_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // State register together with init index and latency pipeline.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            pv_q       <= '0;
            pe_q       <= '0;
            pd_q       <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            pv_q       <= pv_d;
            pe_q       <= pe_d;
            pd_q       <= pd_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Stage 0 captures the response at the accepting edge; the rest just shift.
    always_comb begin
        pv_d    = '0;
        pe_d    = '0;
        pd_d    = '0;
        pv_d[0] = acc;
        pe_d[0] = acc & oor;
        pd_d[0] = (acc && !req_we && !oor) ? rd_word : '0;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    // Outputs are forced to their reset values while rst_n is low, even before the next edge.
    always_comb begin
        req_ready = rst_n & (state_q == ST_RUN);
        init_busy = ~rst_n | (state_q == ST_INIT);
        rsp_valid = rst_n & pv_q[RD_LAT-1];
        rsp_err   = rst_n & pe_q[RD_LAT-1];
        rsp_rdata = rst_n ? pd_q[RD_LAT-1] : '0;
    end

endmodule
